// File: rtl/uart_receiver.sv
// 8N1 UART receiver: recovers bytes from an oversampled serial line, delivers them with a one-cycle strobe.
// Latency: byte/error pulse one clk after the stop-bit centre sample; no backpressure, sample_en low freezes the FSM.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       sample_en,
    output logic [7:0] rx_data,
    output logic       rx_status,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_status_q, rx_status_d;
    logic          rx_frame_err_q, rx_frame_err_d;
    logic          rx_busy_q, rx_busy_d;
    logic          din_s;

    assign din_s = sync2_q;

    always_comb begin
        sync1_d        = din;
        sync2_d        = sync1_q;
        state_d        = state_q;
        tick_d         = tick_q;
        bit_idx_d      = bit_idx_q;
        sh_d           = sh_q;
        rx_data_d      = rx_data_q;
        // Pulses self-clear every clk, independent of sample_en.
        rx_status_d    = 1'b0;
        rx_frame_err_d = 1'b0;

        if (sample_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!din_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d    = '0;
                        bit_idx_d = '0;
                        state_d   = din_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_d    = '0;
                        sh_d      = {din_s, sh_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (din_s) begin
                            rx_data_d   = sh_q;
                            rx_status_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            rx_frame_err_d = 1'b1;
                            state_d        = ST_WAIT_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    // Hold off until the line returns high so a break is not read as 0x00 bytes.
                    if (din_s) begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                end
            endcase
        end

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            state_q        <= ST_IDLE;
            tick_q         <= '0;
            bit_idx_q      <= '0;
            sh_q           <= '0;
            rx_data_q      <= '0;
            rx_status_q    <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rx_busy_q      <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            state_q        <= state_d;
            tick_q         <= tick_d;
            bit_idx_q      <= bit_idx_d;
            sh_q           <= sh_d;
            rx_data_q      <= rx_data_d;
            rx_status_q    <= rx_status_d;
            rx_frame_err_q <= rx_frame_err_d;
            rx_busy_q      <= rx_busy_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_status    = rx_status_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: strobe-timed 8N1 transmitter model, byte/error scoreboard, directed and random frames.
module tb_uart_receiver;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       sample_en;
    logic [7:0] rx_data;
    logic       rx_status;
    logic       rx_frame_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;

    bit stall = 1'b0;

    // Scoreboard: what the model expects vs what the monitor saw.
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         exp_ferr  = 0;
    int         ferr_seen = 0;
    logic [7:0] last_good = 8'h00;
    int         busy_run  = 0;
    int         busy_len  = 0;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .sample_en    (sample_en),
        .rx_data      (rx_data),
        .rx_status    (rx_status),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One strobe every 4 clk; a stall freezes the phase as well.
    initial begin
        int ph;
        ph = 0;
        sample_en = 1'b0;
        forever begin
            @(negedge clk);
            if (stall) begin
                sample_en = 1'b0;
            end else begin
                sample_en = (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rx_status) obs_q.push_back(rx_data);
            if (rx_frame_err) ferr_seen++;
            if (rx_status || rx_frame_err) check("pulse_excl", {31'd0, rx_status & rx_frame_err}, 32'd0);
            if (rx_busy) begin
                busy_run++;
            end else begin
                if (busy_run != 0) busy_len = busy_run;
                busy_run = 0;
            end
        end
    end

    task automatic wait_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sample_en) @(posedge clk);
        end
    endtask

    task automatic send_bits(input logic [9:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            din = fr[i];
            wait_strobes(16);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        send_bits({stop, b, 1'b0}, 10);
        if (stop) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        din = 1'b1;
        wait_strobes(n);
    endtask

    task automatic flush(input string tag);
        int t;
        int n;
        t = 0;
        while ((obs_q.size() < exp_q.size() || ferr_seen < exp_ferr) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        check({tag, "_nferr"}, ferr_seen, exp_ferr);
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, last_good});
        obs_q.delete();
        exp_q.delete();
        ferr_seen = 0;
        exp_ferr  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_status"}, {31'd0, rx_status}, 32'd0);
        check({tag, "_ferr"}, {31'd0, rx_frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         stop;
        rst_n = 1'b0;
        din   = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(20);

        // Short low glitch: aborted at mid-start, busy for 8 strobes.
        @(negedge clk);
        din = 1'b0;
        wait_strobes(5);
        idle(24);
        check("glitch_busy_len", busy_len, 32);
        flush("glitch");

        send_frame(8'hA5, 1'b1);
        idle(8);
        flush("a5");
        check("a5_busy_len", busy_len, 608);

        // Bad stop bit followed by a 3-bit break.
        send_frame(8'h3C, 1'b0);
        @(negedge clk);
        din = 1'b0;
        wait_strobes(48);
        @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        idle(8);
        send_frame(8'h00, 1'b1);
        idle(8);
        flush("break");

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(8);
        flush("b2b");

        // Reset in the middle of bit 4 of 0x81.
        send_bits({1'b1, 8'h81, 1'b0}, 4);
        @(negedge clk);
        din = 1'b0;
        wait_strobes(8);
        @(negedge clk);
        rst_n = 1'b0;
        last_good = 8'h00;
        #1;
        check_reset_outputs("midrst");
        din = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        send_frame(8'h5A, 1'b1);
        idle(8);
        flush("rst");

        fork
            send_frame(8'hC3, 1'b1);
            begin
                wait_strobes(16 * 4 + 5);
                @(posedge clk);
                stall = 1'b1;
                repeat (100) @(posedge clk);
                stall = 1'b0;
            end
        join
        idle(8);
        flush("stall");

        for (int k = 0; k < 15; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop);
            if (!stop) begin
                @(negedge clk);
                din = 1'b0;
                wait_strobes($urandom_range(0, 20));
                idle(3);
            end
        end
        idle(8);
        flush("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
